// File: rtl/key_press_reader_pkg.sv
// Shared FSM state type and board timing constants for the pushbutton reader.
package key_press_reader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HELD      = 2'd1,
        LONG_HELD = 2'd2
    } key_state_e;

    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned MS_CYC = 50_000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_sync_debounce.sv
// Two-flop synchroniser and debounce filter for one active-low button.
// stable is the accepted pin level (1 = released); fall/rise strobe for
// one cycle on the same edge that stable changes.
module key_sync_debounce
    import key_press_reader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 20 * MS_CYC
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic KEY_IN,
    output logic stable,
    output logic fall,
    output logic rise
);

    localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    // Synchronise the pin, then accept a new level only after it has held long enough
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            meta   <= 1'b1;
            sync   <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            fall   <= 1'b0;
            rise   <= 1'b0;
        end else begin
            meta <= KEY_IN;
            sync <= meta;
            fall <= 1'b0;
            rise <= 1'b0;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync;
                cnt    <= '0;
                fall   <= ~sync;
                rise   <= sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_press_reader.sv
// Turns one raw DE2 pushbutton into clean press / short / long / release
// events and reports how long the last completed press was held.
module key_press_reader
    import key_press_reader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 20 * MS_CYC,
    parameter int unsigned LONG_CYC     = CLK_HZ,
    parameter int unsigned DUR_W        = 26
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             KEY_IN,
    output logic             key_down,
    output logic             press_pulse,
    output logic             short_press,
    output logic             long_press,
    output logic             release_pulse,
    output logic [DUR_W-1:0] press_dur
);

    localparam logic [DUR_W-1:0] DUR_LONG = DUR_W'(LONG_CYC - 1);
    localparam logic [DUR_W-1:0] DUR_MAX  = {DUR_W{1'b1}};

    if (DEBOUNCE_CYC == 0 || LONG_CYC == 0 || 64'(LONG_CYC) >= (64'd1 << DUR_W)) begin : g_param_check
        $error("key_press_reader: need DEBOUNCE_CYC >= 1 and 1 <= LONG_CYC < 2**DUR_W");
    end

    logic stable;
    logic fall;
    logic rise;

    key_sync_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY_IN   (KEY_IN),
        .stable   (stable),
        .fall     (fall),
        .rise     (rise)
    );

    key_state_e       state;
    key_state_e       state_nxt;
    logic [DUR_W-1:0] dur;
    logic [DUR_W-1:0] dur_nxt;
    logic [DUR_W-1:0] dur_inc_c;
    logic             press_evt_c;
    logic             release_evt_c;

    logic             key_down_nxt;
    logic             press_pulse_nxt;
    logic             short_press_nxt;
    logic             long_press_nxt;
    logic             release_pulse_nxt;
    logic [DUR_W-1:0] press_dur_nxt;

    // Edge strobes qualified by the level they just produced
    assign press_evt_c   = fall & ~stable;
    assign release_evt_c = rise & stable;
    assign dur_inc_c     = (dur == DUR_MAX) ? DUR_MAX : dur + DUR_W'(1);

    // State, duration counter and all outputs are registered here
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            dur           <= '0;
            key_down      <= 1'b0;
            press_pulse   <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            release_pulse <= 1'b0;
            press_dur     <= '0;
        end else begin
            state         <= state_nxt;
            dur           <= dur_nxt;
            key_down      <= key_down_nxt;
            press_pulse   <= press_pulse_nxt;
            short_press   <= short_press_nxt;
            long_press    <= long_press_nxt;
            release_pulse <= release_pulse_nxt;
            press_dur     <= press_dur_nxt;
        end
    end

    // Next state: release has priority over reaching the long threshold
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (press_evt_c) state_nxt = HELD;
            end
            HELD: begin
                if (release_evt_c)         state_nxt = IDLE;
                else if (dur == DUR_LONG)  state_nxt = LONG_HELD;
            end
            LONG_HELD: begin
                if (release_evt_c) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the event pulses, level, and duration registers
    always_comb begin
        dur_nxt           = dur;
        key_down_nxt      = key_down;
        press_pulse_nxt   = 1'b0;
        short_press_nxt   = 1'b0;
        long_press_nxt    = 1'b0;
        release_pulse_nxt = 1'b0;
        press_dur_nxt     = press_dur;
        case (state)
            IDLE: begin
                if (press_evt_c) begin
                    press_pulse_nxt = 1'b1;
                    key_down_nxt    = 1'b1;
                    dur_nxt         = '0;
                end
            end
            HELD: begin
                dur_nxt = dur_inc_c;
                if (release_evt_c) begin
                    short_press_nxt   = 1'b1;
                    release_pulse_nxt = 1'b1;
                    key_down_nxt      = 1'b0;
                    press_dur_nxt     = dur_inc_c;
                end else if (dur == DUR_LONG) begin
                    long_press_nxt = 1'b1;
                end
            end
            LONG_HELD: begin
                dur_nxt = dur_inc_c;
                if (release_evt_c) begin
                    release_pulse_nxt = 1'b1;
                    key_down_nxt      = 1'b0;
                    press_dur_nxt     = dur_inc_c;
                end
            end
            default: begin
                key_down_nxt = 1'b0;
            end
        endcase
    end

endmodule
